vga_timing: RTL and testbench
=============================

VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 Parameter H_FP, default 16: horizontal front porch, in pixel clocks.
REQ-003 Parameter H_SYNC, default 96: hsync pulse width, in pixel clocks.
REQ-004 Parameter H_BP, default 48: horizontal back porch, in pixel clocks.
REQ-005 Parameter V_ACTIVE, default 480: visible lines per frame.
REQ-006 Parameter V_FP, default 10: vertical front porch, in lines.
REQ-007 Parameter V_SYNC, default 2: vsync pulse width, in lines.
REQ-008 Parameter V_BP, default 33: vertical back porch, in lines.
REQ-009 Parameter SYNC_POL, default 0: sync active level; 0 means active-low.
REQ-010 Port pix_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-011 Port prst, input, 1 bit: reset, synchronous and active-high.
REQ-012 Port hsync, output, 1 bit: horizontal sync.
REQ-013 Port vsync, output, 1 bit: vertical sync.
REQ-014 Port de, output, 1 bit: display enable, high on visible pixels.
REQ-015 Port x, output, 10 bits: current horizontal position, 0..H_TOTAL-1.
REQ-016 Port y, output, 10 bits: current vertical position, 0..V_TOTAL-1.
REQ-017 Port line_start, output, 1 bit: one-cycle pulse at x==0.
REQ-018 Port frame_start, output, 1 bit: one-cycle pulse at x==0, y==0.
REQ-019 Port vblank_start, output, 1 bit: one-cycle pulse at x==0, y==V_ACTIVE; used as the framebuffer swap point.

Function
REQ-020 Totals: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
REQ-021 Both totals SHALL be at most 1024; elaboration SHALL fail otherwise.
REQ-022 Internal h_cnt increments by 1 every cycle; at H_TOTAL-1 it wraps to 0.
REQ-023 Internal v_cnt increments only when h_cnt wraps; at V_TOTAL-1 (with h wrap) it wraps to 0.
REQ-024 Horizontal FSM states H_ACT, H_FP, H_SYN, H_BP.
REQ-025 Horizontal transitions, each on the last cycle of the current phase: H_ACT→H_FP at h_cnt==H_ACTIVE-1; H_FP→H_SYN at H_ACTIVE+H_FP-1; H_SYN→H_BP at H_ACTIVE+H_FP+H_SYNC-1; H_BP→H_ACT at H_TOTAL-1.
REQ-026 Vertical FSM states V_ACT, V_FP, V_SYN, V_BP, transitioning at the analogous v_cnt boundaries, only on the h wrap cycle.
REQ-027 FSM state and counters SHALL always agree; a parameterised check SHALL flag any mismatch in simulation.
REQ-028 All outputs are registered, with 1 cycle latency from (h_cnt, v_cnt, state) to the ports.
REQ-029 x and y equal h_cnt and v_cnt, delayed 1 cycle.
REQ-030 de = (H_ACT and V_ACT).
REQ-031 hsync = SYNC_POL when in H_SYN, otherwise !SYNC_POL.
REQ-032 vsync = SYNC_POL when in V_SYN (whole lines, changing at h_cnt==0), otherwise !SYNC_POL.
REQ-033 line_start, frame_start and vblank_start are exactly 1 cycle wide and never back-to-back.
REQ-034 frame_start and line_start are coincident at the frame origin.
REQ-035 Frame period SHALL be exactly H_TOTAL*V_TOTAL cycles (default 420000); de high H_ACTIVE*V_ACTIVE cycles per frame.

Reset
REQ-036 While prst=1 at a rising edge: h_cnt=0, v_cnt=0, states H_ACT/V_ACT.
REQ-037 While prst=1 at a rising edge: de=0, x=0, y=0, hsync=vsync=!SYNC_POL, all pulses 0.
REQ-038 Reset asserted mid-frame SHALL take effect on the next edge regardless of state, with no partial sync pulse extension.
REQ-039 On the first edge with prst=0, counters sit at (0,0).
REQ-040 Outputs on the edge after that show de=1, x=0, y=0, line_start=1, frame_start=1.
REQ-041 prst comes from the upstream reset generator (already synchronised to pix_clk); no further synchronisation is done here.

Verification
REQ-042 Reset release: prst high 5 cycles then low -> second edge after release gives de=1, x=0, y=0, frame_start=1, hsync=1, vsync=1.
REQ-043 Horizontal timing: every line, hsync=0 for exactly 96 cycles starting at x=656; de=1 for exactly 640 cycles (x=0..639); line period 800 cycles.
REQ-044 Vertical timing: vsync=0 from (x=0, y=490) through (x=799, y=491), i.e. 1600 cycles; de=0 for all y>=480; frame_start spacing 420000 cycles.
REQ-045 Pulses: across 3 frames, exactly 3 frame_start, 3 vblank_start (each at x=0, y=480) and 1575 line_start pulses.
REQ-046 Mid-operation reset: prst high for 3 cycles at x=300, y=200 -> outputs at reset values during the reset, then restart at (0,0) with frame_start=1.
REQ-047 Reset during sync: prst high for 1 cycle at x=700, y=491 -> hsync and vsync return to 1 on the next edge, and the next sync pulses occur at full width.

Source files
------------

// File: rtl/vga_timing.sv
// vga_timing: parameterised VGA raster generator with registered sync, enable, position and pulse outputs
module vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic       pix_clk,
  input  logic       prst,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start,
  output logic       vblank_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic POL = (SYNC_POL != 0);
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing: H_TOTAL and V_TOTAL must not exceed 1024");
  end
  localparam logic [1:0] HS_ACT = 2'd0, HS_FP = 2'd1, HS_SYN = 2'd2, HS_BP = 2'd3;
  localparam logic [1:0] VS_ACT = 2'd0, VS_FP = 2'd1, VS_SYN = 2'd2, VS_BP = 2'd3;
  localparam logic [9:0] H_A_END = 10'(H_ACTIVE - 1);
  localparam logic [9:0] H_F_END = 10'(H_ACTIVE + H_FP - 1);
  localparam logic [9:0] H_S_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_T_END = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_A_END = 10'(V_ACTIVE - 1);
  localparam logic [9:0] V_F_END = 10'(V_ACTIVE + V_FP - 1);
  localparam logic [9:0] V_S_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_T_END = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_BLANK = 10'(V_ACTIVE);
  logic [9:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [1:0] h_st_q, h_st_d, v_st_q, v_st_d;
  logic       h_wrap, v_wrap;
  logic       hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic       line_start_q, line_start_d, frame_start_q, frame_start_d, vblank_start_q, vblank_start_d;
  always_comb begin
    h_wrap = h_cnt_q == H_T_END;
    v_wrap = v_cnt_q == V_T_END;
    h_cnt_d = h_wrap ? '0 : h_cnt_q + 10'd1;
    v_cnt_d = !h_wrap ? v_cnt_q : v_wrap ? '0 : v_cnt_q + 10'd1;
    h_st_d = (h_st_q == HS_ACT && h_cnt_q == H_A_END) ? HS_FP  :
             (h_st_q == HS_FP  && h_cnt_q == H_F_END) ? HS_SYN :
             (h_st_q == HS_SYN && h_cnt_q == H_S_END) ? HS_BP  :
             (h_st_q == HS_BP  && h_wrap)             ? HS_ACT : h_st_q;
    // vertical phase only advances on the last pixel of a line
    v_st_d = !h_wrap ? v_st_q :
             (v_st_q == VS_ACT && v_cnt_q == V_A_END) ? VS_FP  :
             (v_st_q == VS_FP  && v_cnt_q == V_F_END) ? VS_SYN :
             (v_st_q == VS_SYN && v_cnt_q == V_S_END) ? VS_BP  :
             (v_st_q == VS_BP  && v_wrap)             ? VS_ACT : v_st_q;
    de_d           = h_st_q == HS_ACT && v_st_q == VS_ACT;
    hsync_d        = (h_st_q == HS_SYN) ? POL : !POL;
    vsync_d        = (v_st_q == VS_SYN) ? POL : !POL;
    x_d            = h_cnt_q;
    y_d            = v_cnt_q;
    line_start_d   = h_cnt_q == '0;
    frame_start_d  = line_start_d && v_cnt_q == '0;
    vblank_start_d = line_start_d && v_cnt_q == V_BLANK;
  end
  always_ff @(posedge pix_clk) begin
    if (prst) begin
      h_cnt_q        <= '0;
      v_cnt_q        <= '0;
      h_st_q         <= HS_ACT;
      v_st_q         <= VS_ACT;
      de_q           <= 1'b0;
      hsync_q        <= !POL;
      vsync_q        <= !POL;
      x_q            <= '0;
      y_q            <= '0;
      line_start_q   <= 1'b0;
      frame_start_q  <= 1'b0;
      vblank_start_q <= 1'b0;
    end else begin
      h_cnt_q        <= h_cnt_d;
      v_cnt_q        <= v_cnt_d;
      h_st_q         <= h_st_d;
      v_st_q         <= v_st_d;
      de_q           <= de_d;
      hsync_q        <= hsync_d;
      vsync_q        <= vsync_d;
      x_q            <= x_d;
      y_q            <= y_d;
      line_start_q   <= line_start_d;
      frame_start_q  <= frame_start_d;
      vblank_start_q <= vblank_start_d;
    end
  end
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign de           = de_q;
  assign x            = x_q;
  assign y            = y_q;
  assign line_start   = line_start_q;
  assign frame_start  = frame_start_q;
  assign vblank_start = vblank_start_q;
  function automatic logic [1:0] phase(input int c, input int a, input int f, input int s);
    return c < a ? 2'd0 : c < a + f ? 2'd1 : c < a + f + s ? 2'd2 : 2'd3;
  endfunction
  // phase registers must always match the phase implied by the counters
  assert property (@(posedge pix_clk) disable iff (prst)
    h_st_q == phase(int'(h_cnt_q), H_ACTIVE, H_FP, H_SYNC) &&
    v_st_q == phase(int'(v_cnt_q), V_ACTIVE, V_FP, V_SYNC));
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: table vectors, directed reset/pulse sequences and a raster-position reference model
module tb_vga_timing;
  localparam int HA = 8, HF = 2, HS = 3, HB = 3, VA = 6, VF = 2, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB, VT = VA + VF + VS + VB, FT = HT * VT;
  localparam logic [25:0] RST_V = {6'b011000, 20'd0};
  logic clk = 1'b0, prst = 1'b1;
  logic hsync, vsync, de, line_start, frame_start, vblank_start;
  logic [9:0] x, y;
  logic [25:0] got;
  int checks = 0, failures = 0;
  vga_timing #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
               .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(0)) dut (
    .pix_clk(clk), .prst(prst), .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .line_start(line_start), .frame_start(frame_start), .vblank_start(vblank_start));
  always #5 clk = ~clk;
  assign got = {de, hsync, vsync, line_start, frame_start, vblank_start, x, y};
  // reference: outputs are a pure function of the raster index shown this cycle
  function automatic logic [25:0] ref_vec(input logic r, input int p);
    int px, py;
    if (r) return RST_V;
    px = p % HT;
    py = p / HT;
    return {px < HA && py < VA, !(px >= HA + HF && px < HA + HF + HS),
            !(py >= VA + VF && py < VA + VF + VS), px == 0, p == 0, px == 0 && py == VA,
            10'(px), 10'(py)};
  endfunction
  logic m_rst = 1'b1;
  int m_p = 0;
  always @(posedge clk) begin
    m_rst <= prst;
    m_p   <= (prst || m_rst) ? 0 : (m_p + 1) % FT;
  end
  always @(negedge clk) begin
    checks++;
    if (got !== ref_vec(m_rst, m_p)) begin
      failures++;
      $display("FAIL model t=%0t got=%h exp=%h", $time, got, ref_vec(m_rst, m_p));
    end
  end
  task automatic chk(input string name, input logic [31:0] g, input logic [31:0] e);
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, g, e);
    end
  endtask
  task automatic wait_xy(input int xv, input int yv, input string name);
    int k = 0;
    while (!(int'(x) == xv && int'(y) == yv) && k < 2 * FT) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= 2 * FT) begin
      failures++;
      $display("FAIL %s timeout waiting for x=%0d y=%0d got x=%0d y=%0d", name, xv, yv, x, y);
    end
  endtask
  typedef struct { int n; logic [25:0] v; } vec_t;
  function automatic vec_t mk(input int n, input int xv, input int yv, input logic [5:0] f);
    return '{n, {f, 10'(xv), 10'(yv)}};
  endfunction
  vec_t tbl[18];
  initial begin
    int n, fs_c, vb_c, ls_c, de_c, last_fs, gap, hl, vl;
    tbl = '{mk(0, 0, 0, 6'b111110), mk(1, 1, 0, 6'b111000), mk(7, 7, 0, 6'b111000),
            mk(8, 8, 0, 6'b011000), mk(9, 9, 0, 6'b011000), mk(10, 10, 0, 6'b001000),
            mk(12, 12, 0, 6'b001000), mk(13, 13, 0, 6'b011000), mk(15, 15, 0, 6'b011000),
            mk(16, 0, 1, 6'b111100), mk(95, 15, 5, 6'b011000), mk(96, 0, 6, 6'b011101),
            mk(127, 15, 7, 6'b011000), mk(128, 0, 8, 6'b010100), mk(138, 10, 8, 6'b000000),
            mk(159, 15, 9, 6'b010000), mk(160, 0, 10, 6'b011100), mk(192, 0, 0, 6'b111110)};
    prst = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_state", 32'(got), 32'(RST_V));
    prst = 1'b0;
    n = 0;
    @(negedge clk);
    for (int i = 0; i < 18; i++) begin
      while (n < tbl[i].n) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("vec_n%0d", tbl[i].n), 32'(got), 32'(tbl[i].v));
    end
    fs_c = 0; vb_c = 0; ls_c = 0; de_c = 0; last_fs = -1; gap = 0;
    for (int k = 0; k < 3 * FT; k++) begin
      if (frame_start) begin
        if (last_fs >= 0) gap = k - last_fs;
        last_fs = k;
        fs_c++;
      end
      vb_c += int'(vblank_start);
      ls_c += int'(line_start);
      de_c += int'(de);
      @(negedge clk);
    end
    chk("frame_start_count", fs_c, 3);
    chk("vblank_start_count", vb_c, 3);
    chk("line_start_count", ls_c, 3 * VT);
    chk("de_count", de_c, 3 * HA * VA);
    chk("frame_period", gap, FT);
    wait_xy(5, 3, "mid_rst_wait");
    prst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("mid_rst_hold", 32'(got), 32'(RST_V));
    end
    prst = 1'b0;
    @(negedge clk);
    chk("mid_rst_restart", 32'(got), 32'({6'b111110, 20'd0}));
    wait_xy(11, 9, "sync_rst_wait");
    chk("sync_rst_pre", {hsync, vsync}, 2'b00);
    prst = 1'b1;
    @(negedge clk);
    chk("sync_rst_release", {hsync, vsync}, 2'b11);
    prst = 1'b0;
    hl = 0; vl = 0;
    for (int k = 0; k < FT; k++) begin
      @(negedge clk);
      if (k < HT) hl += int'(!hsync);
      vl += int'(!vsync);
    end
    chk("hsync_width_after_rst", hl, HS);
    chk("vsync_width_after_rst", vl, VS * HT);
    for (int r = 0; r < 25; r++) begin
      repeat ($urandom_range(1, 250)) @(negedge clk);
      prst = 1'b1;
      repeat ($urandom_range(1, 4)) @(negedge clk);
      prst = 1'b0;
    end
    repeat (FT + 20) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
